// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM states, LFSR constants
// and the all-9s BCD pattern helper.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_TIME,
        S_SHOW,
        S_FOUL,
        S_DONE
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned BCD_MAX_DIGITS = 8;

    function automatic logic [4*BCD_MAX_DIGITS-1:0] bcd_all9(input int unsigned digits);
        logic [4*BCD_MAX_DIGITS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) v[4*i +: 4] = 4'h9;
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD incrementer that saturates at all-9s instead of wrapping;
// can also be forced straight to all-9s.
module bcd_counter
    import reaction_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                sat,
    input  logic                inc,
    output logic [4*DIGITS-1:0] count,
    output logic                max
);

    localparam int unsigned     W    = 4 * DIGITS;
    localparam logic [W-1:0]    ALL9 = W'(bcd_all9(DIGITS));

    logic [W-1:0] count_q, count_d;
    logic         max_q, max_d;
    logic         carry;

    // Ripple the +1 through the digits, LSD first
    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        if (clr) begin
            count_d = '0;
        end else if (sat) begin
            count_d = ALL9;
        end else if (inc && !max_q) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'h9) begin
                        count_d[4*i +: 4] = 4'h0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'h1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        max_d = (count_d == ALL9);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            max_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    assign count = count_q;
    assign max   = max_q;

endmodule

// File: rtl/reaction_timer_rounds.sv
// Multi-round reaction timer: random wait, LED, BCD ms measurement, foul and
// timeout detection, best-time tracking over ROUNDS attempts.
module reaction_timer_rounds
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned DIGITS       = 3,
    parameter int unsigned ROUNDS       = 4,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_BITS   = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    output logic                         led,
    output logic [4*DIGITS-1:0]          time_bcd,
    output logic [4*DIGITS-1:0]          best_bcd,
    output logic [$clog2(ROUNDS+1)-1:0]  round_idx,
    output logic                         foul,
    output logic                         run_done,
    output logic                         done_tick
);

    localparam int unsigned  TW   = 4 * DIGITS;
    localparam int unsigned  RW   = $clog2(ROUNDS + 1);
    localparam int unsigned  PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned  DW   = $clog2(MIN_DELAY_MS + 2**DELAY_BITS);
    localparam logic [TW-1:0] ALL9 = TW'(bcd_all9(DIGITS));

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [TW-1:0]   best_q, best_d;
    logic [RW-1:0]   round_q, round_d;
    logic            led_q, foul_q, run_done_q, done_tick_q, done_tick_d;
    logic            tick_c;
    logic            cnt_clr, cnt_sat, cnt_inc, cnt_max;
    logic [TW-1:0]   cnt_val;
    logic [DW-1:0]   dly_load;

    assign tick_c   = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d  = tick_c ? '0 : presc_q + PW'(1);
    assign lfsr_d   = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    assign dly_load = DW'(MIN_DELAY_MS) + DW'(lfsr_q[DELAY_BITS-1:0]);

    bcd_counter #(.DIGITS(DIGITS)) u_time (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .sat   (cnt_sat),
        .inc   (cnt_inc),
        .count (cnt_val),
        .max   (cnt_max)
    );

    // Next-state logic; a timeout tick finishes the round exactly like stop
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        best_d      = best_q;
        round_d     = round_q;
        cnt_clr     = 1'b0;
        cnt_sat     = 1'b0;
        cnt_inc     = 1'b0;
        done_tick_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    dly_d   = dly_load;
                    cnt_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_FOUL;
                    cnt_sat = 1'b1;
                end else if (dly_q == '0) begin
                    state_d = S_TIME;
                end else if (tick_c) begin
                    dly_d = dly_q - DW'(1);
                end
            end
            S_TIME: begin
                if (stop || (tick_c && cnt_max)) begin
                    state_d     = S_SHOW;
                    done_tick_d = 1'b1;
                    round_d     = round_q + RW'(1);
                    if (cnt_val < best_q) best_d = cnt_val;
                end else if (tick_c) begin
                    cnt_inc = 1'b1;
                end
            end
            S_SHOW: begin
                if (start) begin
                    if (round_q == RW'(ROUNDS)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        dly_d   = dly_load;
                        cnt_clr = 1'b1;
                    end
                end
            end
            S_FOUL: begin
                if (start) begin
                    state_d = S_WAIT;
                    dly_d   = dly_load;
                    cnt_clr = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    dly_d   = dly_load;
                    cnt_clr = 1'b1;
                    best_d  = ALL9;
                    round_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            dly_q       <= '0;
            best_q      <= ALL9;
            round_q     <= '0;
            led_q       <= 1'b0;
            foul_q      <= 1'b0;
            run_done_q  <= 1'b0;
            done_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lfsr_q      <= lfsr_d;
            dly_q       <= dly_d;
            best_q      <= best_d;
            round_q     <= round_d;
            led_q       <= (state_d == S_TIME);
            foul_q      <= (state_d == S_FOUL);
            run_done_q  <= (state_d == S_DONE);
            done_tick_q <= done_tick_d;
        end
    end

    assign led       = led_q;
    assign time_bcd  = cnt_val;
    assign best_bcd  = best_q;
    assign round_idx = round_q;
    assign foul      = foul_q;
    assign run_done  = run_done_q;
    assign done_tick = done_tick_q;

endmodule

// File: tb/tb_reaction_timer_rounds.sv
// Scoreboard bench: round results are queued at stop time and checked by
// monitors on every done_tick; state checks are made inline.
module tb_reaction_timer_rounds;

    logic clk = 1'b0;
    logic reset;
    logic start_a, stop_a, start_b, stop_b;

    logic        led_a, foul_a, run_done_a, done_tick_a;
    logic [11:0] time_a, best_a;
    logic [1:0]  round_a;
    logic        led_b, foul_b, run_done_b, done_tick_b;
    logic [7:0]  time_b, best_b;
    logic [1:0]  round_b;

    typedef struct packed {
        logic [11:0] t;
        logic [11:0] b;
        logic [1:0]  r;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tb_presc;
    logic prev_dt_a, prev_dt_b;

    always #5 clk = ~clk;

    reaction_timer_rounds #(.TICK_DIV(4), .DIGITS(3), .ROUNDS(3), .MIN_DELAY_MS(2), .DELAY_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .led(led_a),
        .time_bcd(time_a), .best_bcd(best_a), .round_idx(round_a), .foul(foul_a),
        .run_done(run_done_a), .done_tick(done_tick_a)
    );

    reaction_timer_rounds #(.TICK_DIV(4), .DIGITS(2), .ROUNDS(3), .MIN_DELAY_MS(2), .DELAY_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .led(led_b),
        .time_bcd(time_b), .best_bcd(best_b), .round_idx(round_b), .foul(foul_b),
        .run_done(run_done_b), .done_tick(done_tick_b)
    );

    // Reference ms prescaler: a tick happens on the edge where it wraps
    always @(posedge clk or posedge reset) begin
        if (reset) tb_presc <= 0;
        else       tb_presc <= (tb_presc == 3) ? 0 : tb_presc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_dt_a = 1'b0;
        end else begin
            if (prev_dt_a) chk("a_done_tick_width", {31'd0, done_tick_a}, 32'd0);
            if (done_tick_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_done_tick", {31'd0, done_tick_a}, 32'd0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    chk("a_time", {20'd0, time_a}, {20'd0, e.t});
                    chk("a_best", {20'd0, best_a}, {20'd0, e.b});
                    chk("a_round", {30'd0, round_a}, {30'd0, e.r});
                end
            end
            prev_dt_a = done_tick_a;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_dt_b = 1'b0;
        end else begin
            if (prev_dt_b) chk("b_done_tick_width", {31'd0, done_tick_b}, 32'd0);
            if (done_tick_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_done_tick", {31'd0, done_tick_b}, 32'd0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    chk("b_time", {24'd0, time_b}, {20'd0, e.t});
                    chk("b_best", {24'd0, best_b}, {20'd0, e.b});
                    chk("b_round", {30'd0, round_b}, {30'd0, e.r});
                end
            end
            prev_dt_b = done_tick_b;
        end
    end

    // All stimulus tasks start and end just after a falling edge
    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_led_a();
        int i;
        i = 0;
        while (!led_a && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!led_a) chk("a_led_timeout", {31'd0, led_a}, 32'd1);
    endtask

    task automatic count_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            if (tb_presc == 3) k++;
            @(negedge clk);
        end
    endtask

    task automatic play_round_a(input int n, input logic both, input exp_t e);
        wait_led_a();
        count_ticks(n);
        q_a.push_back(e);
        stop_a  = 1'b1;
        start_a = both;
        @(negedge clk);
        stop_a  = 1'b0;
        start_a = 1'b0;
    endtask

    initial begin
        int i;
        reset   = 1'b1;
        start_a = 1'b0;
        stop_a  = 1'b0;
        start_b = 1'b0;
        stop_b  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_led", {31'd0, led_a}, 32'd0);
        chk("rst_time", {20'd0, time_a}, 32'h000);
        chk("rst_best", {20'd0, best_a}, 32'h999);
        chk("rst_round", {30'd0, round_a}, 32'd0);
        chk("rst_foul", {31'd0, foul_a}, 32'd0);
        chk("rst_run_done", {31'd0, run_done_a}, 32'd0);
        chk("rst_done_tick", {31'd0, done_tick_a}, 32'd0);

        pulse_start_a();
        chk("wait_led_low", {31'd0, led_a}, 32'd0);
        play_round_a(37, 1'b0, '{t: 12'h037, b: 12'h037, r: 2'd1});
        chk("r1_led_off", {31'd0, led_a}, 32'd0);

        // Foul: stop early in the wait
        pulse_start_a();
        @(negedge clk);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        chk("foul_flag", {31'd0, foul_a}, 32'd1);
        chk("foul_time", {20'd0, time_a}, 32'h999);
        chk("foul_round", {30'd0, round_a}, 32'd1);
        chk("foul_led", {31'd0, led_a}, 32'd0);

        pulse_start_a();
        chk("rearm_foul_clr", {31'd0, foul_a}, 32'd0);
        play_round_a(12, 1'b0, '{t: 12'h012, b: 12'h012, r: 2'd2});

        pulse_start_a();
        play_round_a(50, 1'b0, '{t: 12'h050, b: 12'h012, r: 2'd3});

        pulse_start_a();
        chk("done_flag", {31'd0, run_done_a}, 32'd1);
        chk("done_best", {20'd0, best_a}, 32'h012);
        chk("done_led", {31'd0, led_a}, 32'd0);

        pulse_start_a();
        chk("newrun_done_clr", {31'd0, run_done_a}, 32'd0);
        chk("newrun_best", {20'd0, best_a}, 32'h999);
        chk("newrun_round", {30'd0, round_a}, 32'd0);

        // Simultaneous start+stop in TIME behaves as stop
        play_round_a(20, 1'b1, '{t: 12'h020, b: 12'h020, r: 2'd1});
        chk("both_led", {31'd0, led_a}, 32'd0);
        chk("both_time", {20'd0, time_a}, 32'h020);
        chk("both_run_done", {31'd0, run_done_a}, 32'd0);
        repeat (3) @(negedge clk);
        chk("both_time_held", {20'd0, time_a}, 32'h020);

        // Asynchronous reset in the middle of a timed round
        pulse_start_a();
        chk("show_to_wait", {31'd0, run_done_a}, 32'd0);
        wait_led_a();
        count_ticks(5);
        #2 reset = 1'b1;
        #1;
        chk("async_led", {31'd0, led_a}, 32'd0);
        chk("async_time", {20'd0, time_a}, 32'h000);
        chk("async_best", {20'd0, best_a}, 32'h999);
        chk("async_round", {30'd0, round_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Timeout on the 2-digit instance
        q_b.push_back('{t: 12'h099, b: 12'h099, r: 2'd1});
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        i = 0;
        while (q_b.size() != 0 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        chk("b_timeout_seen", q_b.size(), 32'd0);
        chk("b_timeout_led", {31'd0, led_b}, 32'd0);
        chk("b_timeout_time", {24'd0, time_b}, 32'h99);

        repeat (2) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reaction_timer_rounds.md
# reaction_timer_rounds

Parametrised multi-round reaction timer core. It generates a pseudo-random wait after `start`, then lights the LED and measures the response time in BCD milliseconds until `stop`. It also detects early (foul) presses and over-range (timeout) responses, and tracks the best time over a run of `ROUNDS` attempts. It sits between the debounced button logic and the hex display mux; its BCD outputs feed the mux digit inputs directly.

## Interface
- `TICK_DIV`, 50000: clk cycles per millisecond tick (50 MHz clock).
- `DIGITS`, 3: BCD digits of the time and best registers; maximum value 10^DIGITS−1.
- `ROUNDS`, 4: attempts per run, ≥1.
- `MIN_DELAY_MS`, 1000: fixed part of the random wait.
- `DELAY_BITS`, 11: random part of the wait = LFSR[DELAY_BITS−1:0] ms (0..2047).
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse, debounced.
- `stop` in 1: one-cycle pulse, debounced.
- `led` out 1: high while the response window is open.
- `time_bcd` out 4·DIGITS: current/last reaction time, digit 0 = LSD.
- `best_bcd` out 4·DIGITS: best valid time in this run.
- `round_idx` out $clog2(ROUNDS+1): completed valid rounds.
- `foul` out 1: high in FOUL state.
- `run_done` out 1: high in DONE state.
- `done_tick` out 1: one-cycle pulse on every valid round completion.

## Operation
- States (in shared package): IDLE, WAIT, TIME, SHOW, FOUL, DONE.
- IDLE: `start` → load delay = MIN_DELAY_MS + LFSR slice, clear `time_bcd` → WAIT.
- WAIT: decrement the delay on each ms tick; reaching 0 → TIME, with `led`=1. `stop` in WAIT → FOUL; the round is not counted.
- TIME: the BCD counter increments on each ms tick. `stop` → freeze the time, pulse `done_tick`, increment `round_idx`, update best if time < best → SHOW. If the counter is at all-9s when a tick arrives, it saturates and the FSM behaves as if `stop` were pressed (timeout; the value counts as all-9s).
- SHOW: `start` → WAIT for the next round; if `round_idx`==ROUNDS, go to DONE instead, without starting a round.
- FOUL: `time_bcd` holds all-9s and `foul`=1. `start` → WAIT, re-arming the same round.
- DONE: `best_bcd` holds; `start` → clear best to all-9s, set `round_idx`=0 → WAIT.
- `start` and `stop` in the same cycle: `stop` takes priority in WAIT/TIME; `start` is ignored there.
- `start` in WAIT/TIME is ignored. `stop` in IDLE/SHOW/FOUL/DONE is ignored.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. It advances every clk and is never all-zero.
- Best comparison is unsigned on the packed BCD vector, which is valid because the digits are ordered MSD-high.

## Timing
- Reset values: `led`=0, `time_bcd`=0, `best_bcd`=all-9s, `round_idx`=0, `foul`=0, `run_done`=0, `done_tick`=0, prescaler=0, LFSR=seed, state IDLE.
- The ms prescaler is free-running from reset. The first tick after a `start` therefore arrives within 1..TICK_DIV cycles, so delay/time resolution is ±1 ms.
- `led` rises on the clk edge after the delay count reaches 0. `time_bcd` first increments on the next tick.
- `stop` at edge n: `led`=0, `time_bcd` frozen, `done_tick`=1 and `best_bcd`/`round_idx` updated, all visible after edge n. `done_tick` is low after edge n+1.
- A tick coinciding with `stop` is not counted.
- All outputs are registered; none is combinational from `start`/`stop`.

## Structure
- Package `reaction_pkg`: state enum, LFSR seed/taps, and `bcd_all9(DIGITS)` helper.
- Sub-module `bcd_counter`: DIGITS-digit BCD incrementer with `clr`, `inc` and a `max` flag (saturates, no wrap). Instantiated once for the time register.
- The prescaler, delay down-counter, LFSR and FSM are inline.

## Test plan
- Reset mid-TIME (TICK_DIV=4): assert `reset` asynchronously → `led`=0, `time_bcd`=0, `best_bcd`=12'h999 immediately, without waiting for a clk edge.
- Normal round (TICK_DIV=4, MIN_DELAY_MS=2, DELAY_BITS=1): `start`, wait until `led`=1, then 37 ticks, then `stop` → `time_bcd`=12'h037, `done_tick` one cycle, `round_idx`=1, `best_bcd`=12'h037.
- Best tracking: rounds of 37, 12 and 50 ms → `best_bcd`=12'h012 after round 2 and unchanged after round 3. With ROUNDS=3, the next `start` → `run_done`=1.
- Foul: `stop` during WAIT → `foul`=1, `time_bcd`=12'h999, `round_idx` unchanged. A subsequent `start` re-enters WAIT.
- Timeout (DIGITS=2): hold with no `stop` → the counter reaches 8'h99, and the next tick ends the round with `time_bcd`=8'h99 and `done_tick`=1.
- Simultaneous `start`+`stop` in TIME at 20 ms → treated as `stop` only: `time_bcd`=12'h020, state SHOW.
